// File: rtl/vga_pkg.sv
// Shared 640x480 VGA timing and tile-map constants, reused by the timing generator
// and the tile RAM arbiter.
package vga_pkg;

    localparam int H_TOTAL    = 800;
    localparam int V_TOTAL    = 525;
    localparam int H_ACTIVE   = 640;
    localparam int V_ACTIVE   = 480;
    localparam int TILE_SHIFT = 4;
    localparam int COLS       = H_ACTIVE >> TILE_SHIFT;
    localparam int ROWS       = V_ACTIVE >> TILE_SHIFT;
    localparam int TILE_W     = 4;
    localparam int ADDR_W     = 11;

    typedef enum logic [TILE_W-1:0] {
        EMPTY = 4'd0,
        SNAKE = 4'd1,
        FOOD  = 4'd2,
        WALL  = 4'd3
    } tile_t;

    // Pixel coordinates to row-major tile address (row*COLS + col).
    function automatic logic [ADDR_W-1:0] tile_addr(input logic [9:0] x, input logic [9:0] y);
        return ADDR_W'((int'(y) >> TILE_SHIFT) * COLS + (int'(x) >> TILE_SHIFT));
    endfunction

endpackage

// File: rtl/fetch_scheduler.sv
// Decodes the timing counters into a display-fetch strobe and the tile address to fetch,
// three cycles ahead of the pixel that needs it.
module fetch_scheduler
    import vga_pkg::*;
(
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    output logic              fetch,
    output logic [ADDR_W-1:0] fetch_addr
);

    logic [9:0] vnext;

    always_comb begin
        vnext      = (vcount == 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 10'd1;
        fetch      = 1'b0;
        fetch_addr = '0;
        if (hcount[3:0] == 4'd13 && hcount <= 10'd621 && vcount < 10'(V_ACTIVE)) begin
            // Next tile to the right of the one being drawn.
            fetch      = 1'b1;
            fetch_addr = tile_addr(hcount + 10'd16, vcount);
        end else if (hcount == 10'(H_TOTAL - 3) && vcount < 10'(V_TOTAL)
                     && vnext < 10'(V_ACTIVE)) begin
            // First tile of the upcoming line, fetched during horizontal blanking.
            fetch      = 1'b1;
            fetch_addr = tile_addr(10'd0, vnext);
        end
    end

endmodule

// File: rtl/tile_ram_arbiter.sv
// Shares the single-port tile RAM between VGA scanout (fixed schedule, always wins)
// and the game logic (req/gnt on every remaining cycle, at most one grant per two cycles).
module tile_ram_arbiter
    import vga_pkg::*;
(
    input  logic              clk25,
    input  logic              reset,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    output logic [TILE_W-1:0] tile_code,
    input  logic              gm_req,
    input  logic              gm_we,
    input  logic [ADDR_W-1:0] gm_addr,
    input  logic [TILE_W-1:0] gm_wdata,
    output logic              gm_gnt,
    output logic              gm_rvalid,
    output logic [TILE_W-1:0] gm_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [TILE_W-1:0] ram_wdata,
    input  logic [TILE_W-1:0] ram_rdata
);

    logic              fetch;
    logic [ADDR_W-1:0] fetch_addr;
    logic              in_range;
    logic              disp_s1, rd_s1, bad_s1;
    logic              disp_s2, rd_s2, bad_s2;

    fetch_scheduler u_sched (
        .hcount     (hcount),
        .vcount     (vcount),
        .fetch      (fetch),
        .fetch_addr (fetch_addr)
    );

    assign in_range = gm_addr < ADDR_W'(COLS * ROWS);

    // s1 tags the access currently on ram_*, s2 tags the data arriving on ram_rdata.
    always_ff @(posedge clk25) begin
        if (reset) begin
            tile_code <= '0;
            gm_gnt    <= 1'b0;
            gm_rvalid <= 1'b0;
            gm_rdata  <= '0;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
            disp_s1   <= 1'b0;
            rd_s1     <= 1'b0;
            bad_s1    <= 1'b0;
            disp_s2   <= 1'b0;
            rd_s2     <= 1'b0;
            bad_s2    <= 1'b0;
        end else begin
            disp_s1 <= 1'b0;
            rd_s1   <= 1'b0;
            bad_s1  <= 1'b0;
            gm_gnt  <= 1'b0;
            ram_we  <= 1'b0;
            if (fetch) begin
                ram_addr <= fetch_addr;
                disp_s1  <= 1'b1;
            end else if (gm_req && !gm_gnt) begin
                // Out-of-map addresses are granted but never written; reads return zero.
                ram_addr  <= gm_addr;
                ram_we    <= gm_we && in_range;
                ram_wdata <= gm_wdata;
                gm_gnt    <= 1'b1;
                rd_s1     <= !gm_we;
                bad_s1    <= !in_range;
            end

            disp_s2   <= disp_s1;
            rd_s2     <= rd_s1;
            bad_s2    <= bad_s1;
            gm_rvalid <= rd_s2;
            if (disp_s2)
                tile_code <= ram_rdata;
            if (rd_s2)
                gm_rdata <= bad_s2 ? '0 : ram_rdata;
        end
    end

endmodule
